// File: rtl/mole_pkg.sv
// Shared constants for the mole placement random source: LFSR tap table,
// core mode encodings and the request FSM state type.
package mole_pkg;

    localparam int unsigned MOLE_MODE_ADD  = 0;
    localparam int unsigned MOLE_MODE_LFSR = 1;

    // Galois right-shift masks for maximal-length sequences, indexed by width
    localparam logic [15:0] MOLE_LFSR_TAPS [4:16] = '{
        16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
        16'h0500, 16'h0E08, 16'h1C80, 16'h3802, 16'h6000, 16'hB400
    };

    typedef enum logic {IDLE, PEND} mole_state_e;

endpackage

// File: rtl/mole_rng_core.sv
// Free-running number core: additive Fibonacci-mod (A/B) or Galois LFSR (S),
// with runtime seed loading and seed sanitising.
module mole_rng_core
    import mole_pkg::*;
#(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned RANGE  = 500,
    parameter int unsigned MODE   = 0,
    parameter int unsigned SEED_A = 1,
    parameter int unsigned SEED_B = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] core
);

    if (MODE == MOLE_MODE_LFSR) begin : g_lfsr
        localparam logic [WIDTH-1:0] Taps = WIDTH'(MOLE_LFSR_TAPS[WIDTH]);

        logic [WIDTH-1:0] s_q, s_d, seed_s;

        always_comb begin
            seed_s = (seed_in == '0) ? WIDTH'(1) : seed_in;
            if (seed_load) begin
                s_d = seed_s;
            end else if (s_q == '0) begin
                s_d = WIDTH'(1);
            end else begin
                s_d = (s_q >> 1) ^ (s_q[0] ? Taps : '0);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) s_q <= WIDTH'(SEED_A);
            else        s_q <= s_d;
        end

        assign core = s_q;
    end else begin : g_add
        localparam logic [WIDTH-1:0] RangeW   = WIDTH'(RANGE);
        localparam logic [WIDTH:0]   RangeSum = (WIDTH+1)'(RANGE);

        logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n, seed_s;
        logic [WIDTH:0]   sum;

        always_comb begin
            sum = {1'b0, a_q} + {1'b0, b_q};
            // Both registers stay within 1..RANGE, so the wrapped sum fits WIDTH bits
            n = WIDTH'((sum > RangeSum) ? (sum - RangeSum) : sum);
            if (n == '0) n = WIDTH'(1);
            seed_s = ((seed_in == '0) || (seed_in > RangeW)) ? WIDTH'(1) : seed_in;
            if (seed_load) begin
                a_d = seed_s;
                b_d = WIDTH'(1);
            end else begin
                a_d = n;
                b_d = a_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= WIDTH'(SEED_A);
                b_q <= WIDTH'(SEED_B);
            end else begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end

        assign core = a_q;
    end

endmodule

// File: rtl/mole_rng.sv
// Mole placement random source: core plus req/valid capture FSM returning 1..RANGE.
// Optional MOLE_RNG_NO_REPEAT_EN rejects a value equal to the last delivery.
module mole_rng
    import mole_pkg::*;
#(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned RANGE  = 500,
    parameter int unsigned MODE   = 0,
    parameter int unsigned SEED_A = 1,
    parameter int unsigned SEED_B = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    output logic             busy
);

    localparam logic [WIDTH-1:0] RangeW = WIDTH'(RANGE);

    logic [WIDTH-1:0] core;
    logic [WIDTH-1:0] rnd_q;
    logic             rnd_valid_q;
    logic             in_range, acceptable, capture;
    mole_state_e      state_q, state_d;

    mole_rng_core #(
        .WIDTH  (WIDTH),
        .RANGE  (RANGE),
        .MODE   (MODE),
        .SEED_A (SEED_A),
        .SEED_B (SEED_B)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .core      (core)
    );

    assign in_range = (core != '0) && (core <= RangeW);
`ifdef MOLE_RNG_NO_REPEAT_EN
    assign acceptable = in_range && (core != rnd_q);
`else
    assign acceptable = in_range;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req && !acceptable) state_d = PEND;
            PEND:    if (acceptable)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req while pending is ignored, so only the state decides a PEND capture
    always_comb begin
        capture = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE:    capture = req && acceptable;
            PEND: begin
                capture = acceptable;
                busy    = 1'b1;
            end
            default: capture = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q       <= '0;
            rnd_valid_q <= 1'b0;
        end else begin
            rnd_valid_q <= capture;
            if (capture) rnd_q <= core;
        end
    end

    assign rnd       = rnd_q;
    assign rnd_valid = rnd_valid_q;

endmodule

// File: tb/tb_mole_rng.sv
// Directed bench for mole_rng: additive defaults, seeding, LFSR pending path,
// reset abort and seed/req collisions; no-repeat scenario when the macro is set.
module tb_mole_rng;

    logic       clk;
    logic       rst_n;

    logic       a_seed_load, a_req, a_valid, a_busy;
    logic [9:0] a_seed_in, a_rnd;

    logic       l_seed_load, l_req, l_valid, l_busy;
    logic [3:0] l_seed_in, l_rnd;

    int checks;
    int errors;
    int busy_run;

    mole_rng u_add (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (a_seed_load),
        .seed_in   (a_seed_in),
        .req       (a_req),
        .rnd       (a_rnd),
        .rnd_valid (a_valid),
        .busy      (a_busy)
    );

    mole_rng #(
        .WIDTH  (4),
        .RANGE  (5),
        .MODE   (1),
        .SEED_A (1),
        .SEED_B (1)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (l_seed_load),
        .seed_in   (l_seed_in),
        .req       (l_req),
        .rnd       (l_rnd),
        .rnd_valid (l_valid),
        .busy      (l_busy)
    );

`ifdef MOLE_RNG_NO_REPEAT_EN
    logic       n_req, n_valid, n_busy;
    logic [3:0] n_rnd;

    mole_rng #(
        .WIDTH  (4),
        .RANGE  (2),
        .MODE   (1),
        .SEED_A (1),
        .SEED_B (1)
    ) u_norep (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (1'b0),
        .seed_in   (4'd0),
        .req       (n_req),
        .rnd       (n_rnd),
        .rnd_valid (n_valid),
        .busy      (n_busy)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // busy on the LFSR instance must never outlast one full LFSR period
    always @(negedge clk) begin
        if (l_busy) begin
            busy_run = busy_run + 1;
        end else if (busy_run != 0) begin
            checks++;
            if (busy_run > 15) begin
                errors++;
                $display("FAIL lfsr_busy_len: got %0d cycles, want <= 15", busy_run);
            end
            busy_run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        a_req = 1'b0; a_seed_load = 1'b0; a_seed_in = '0;
        l_req = 1'b0; l_seed_load = 1'b0; l_seed_in = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (a_rnd !== 10'd0 || a_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_add: got rnd=%0d valid=%b busy=%b, want 0/0/0",
                     a_rnd, a_valid, a_busy);
        end
        checks++;
        if (l_rnd !== 4'd0 || l_valid !== 1'b0 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_lfsr: got rnd=%0d valid=%b busy=%b, want 0/0/0",
                     l_rnd, l_valid, l_busy);
        end
    endtask

    task automatic test_additive();
        int exp_seq [16] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 110, 487, 97};
        do_reset();
        a_req = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (a_rnd !== exp_seq[i][9:0] || a_valid !== 1'b1) begin
                errors++;
                $display("FAIL add_seq[%0d]: got rnd=%0d valid=%b, want %0d/1",
                         i, a_rnd, a_valid, exp_seq[i]);
            end
        end
        a_req = 1'b0;
    endtask

    task automatic test_seed();
        int exp_seq [4] = '{1, 2, 3, 5};
        int seeds [2] = '{0, 600};
        for (int s = 0; s < 2; s++) begin
            a_seed_load = 1'b1;
            a_seed_in   = seeds[s][9:0];
            @(negedge clk);
            a_seed_load = 1'b0;
            a_req       = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checks++;
                if (a_rnd !== exp_seq[i][9:0] || a_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL add_seed%0d[%0d]: got rnd=%0d valid=%b, want %0d/1",
                             seeds[s], i, a_rnd, a_valid, exp_seq[i]);
                end
            end
            a_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_lfsr();
        int exp_del [8] = '{1, 3, 5, 4, 2, 1, 3, 5};
        int k;
        int cyc;
        do_reset();
        l_req = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (l_rnd !== 4'd1 || l_valid !== 1'b1 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL lfsr_first: got rnd=%0d valid=%b busy=%b, want 1/1/0",
                     l_rnd, l_valid, l_busy);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (l_busy !== 1'b1 || l_valid !== 1'b0 || l_rnd !== 4'd1) begin
                errors++;
                $display("FAIL lfsr_pend[%0d]: got busy=%b valid=%b rnd=%0d, want 1/0/1",
                         i, l_busy, l_valid, l_rnd);
            end
        end
        @(negedge clk);
        checks++;
        if (l_rnd !== 4'd3 || l_valid !== 1'b1 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL lfsr_second: got rnd=%0d valid=%b busy=%b, want 3/1/0",
                     l_rnd, l_valid, l_busy);
        end
        k = 2;
        cyc = 0;
        while (k < 8 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (l_valid) begin
                checks++;
                if (l_rnd !== exp_del[k][3:0]) begin
                    errors++;
                    $display("FAIL lfsr_del[%0d]: got %0d, want %0d", k, l_rnd, exp_del[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL lfsr_del_timeout: got %0d deliveries, want 8", k);
        end
        l_req = 1'b0;
    endtask

    task automatic test_reset_mid_pend();
        do_reset();
        l_req = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (l_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: got busy=%b, want 1", l_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (l_busy !== 1'b0 || l_rnd !== 4'd0 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: got busy=%b rnd=%0d valid=%b, want 0/0/0",
                     l_busy, l_rnd, l_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (l_rnd !== 4'd1 || l_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_replay1: got rnd=%0d valid=%b, want 1/1", l_rnd, l_valid);
        end
        @(negedge clk);
        checks++;
        if (l_busy !== 1'b1 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_replay2: got busy=%b valid=%b, want 1/0", l_busy, l_valid);
        end
        l_req = 1'b0;
    endtask

    // Request and reload on the same edge: the request sees the old core value 12
    task automatic test_req_with_seed();
        do_reset();
        rst_n = 1'b1;
        @(negedge clk);
        l_req       = 1'b1;
        l_seed_load = 1'b1;
        l_seed_in   = 4'd3;
        @(negedge clk);
        l_req       = 1'b0;
        l_seed_load = 1'b0;
        checks++;
        if (l_busy !== 1'b1 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL reqseed_pend: got busy=%b valid=%b, want 1/0", l_busy, l_valid);
        end
        @(negedge clk);
        checks++;
        if (l_rnd !== 4'd3 || l_valid !== 1'b1 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL reqseed_cap: got rnd=%0d valid=%b busy=%b, want 3/1/0",
                     l_rnd, l_valid, l_busy);
        end
    endtask

    task automatic test_pend_seed();
        int pulses;
        do_reset();
        l_req = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        l_seed_load = 1'b1;
        l_seed_in   = 4'd4;
        @(negedge clk);
        l_req       = 1'b0;
        l_seed_load = 1'b0;
        checks++;
        if (l_busy !== 1'b1 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL pendseed_stay: got busy=%b valid=%b, want 1/0", l_busy, l_valid);
        end
        @(negedge clk);
        checks++;
        if (l_rnd !== 4'd4 || l_valid !== 1'b1 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL pendseed_cap: got rnd=%0d valid=%b busy=%b, want 4/1/0",
                     l_rnd, l_valid, l_busy);
        end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (l_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || l_rnd !== 4'd4) begin
            errors++;
            $display("FAIL pendseed_drop: got %0d extra pulses rnd=%0d, want 0 and 4",
                     pulses, l_rnd);
        end
    endtask

`ifdef MOLE_RNG_NO_REPEAT_EN
    task automatic test_no_repeat();
        logic [3:0] prev;
        int cnt;
        int busy_cyc;
        do_reset();
        n_req = 1'b0;
        rst_n = 1'b1;
        prev  = 4'd0;
        for (int p = 0; p < 200; p++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_req = 1'b1;
            @(negedge clk);
            n_req = 1'b0;
            cnt = 0;
            busy_cyc = n_busy ? 1 : 0;
            while (!n_valid && cnt < 20) begin
                @(negedge clk);
                cnt++;
                if (n_busy) busy_cyc++;
            end
            checks++;
            if (!n_valid || n_rnd == prev || n_rnd == 4'd0 || n_rnd > 4'd2 || busy_cyc > 15) begin
                errors++;
                $display("FAIL norep[%0d]: got rnd=%0d prev=%0d valid=%b busy=%0d",
                         p, n_rnd, prev, n_valid, busy_cyc);
            end
            prev = n_rnd;
        end
    endtask
`endif

    initial begin
        checks   = 0;
        errors   = 0;
        busy_run = 0;
        rst_n    = 1'b0;
        a_req = 1'b0; a_seed_load = 1'b0; a_seed_in = '0;
        l_req = 1'b0; l_seed_load = 1'b0; l_seed_in = '0;
`ifdef MOLE_RNG_NO_REPEAT_EN
        n_req = 1'b0;
`endif
        test_reset();
        test_additive();
        test_seed();
        test_lfsr();
        test_reset_mid_pend();
        test_req_with_seed();
        test_pend_seed();
`ifdef MOLE_RNG_NO_REPEAT_EN
        test_no_repeat();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mole_rng.md
# mole_rng

Parametrised pseudo-random source for mole placement. It replaces the fixed 10-bit additive generator with a configurable generator that supports:
- a selectable core (additive Fibonacci-mod or Galois LFSR);
- runtime seeding;
- a req/valid capture handshake that only returns values in 1..RANGE.

It sits between the game controller, which issues requests, and the mole position/timer logic, which consumes `rnd`.

## Interface
- `WIDTH`, 10: bit width of core state and `rnd`. Legal range 4..16.
- `RANGE`, 500: upper bound of returned values. Returned values are 1..RANGE. Requires 1 ≤ RANGE < 2^WIDTH.
- `MODE`, 0: 0 = additive Fibonacci-mod core; 1 = Galois LFSR core.
- `SEED_A`, 1: reset value of core register A (additive) or LFSR state. Must be nonzero.
- `SEED_B`, 1: reset value of core register B (additive mode only). Must be nonzero.
- `clk` input, 1: single clock. All logic is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `seed_load` input, 1: reload the core from `seed_in` at this edge.
- `seed_in` input, WIDTH: seed value.
- `req` input, 1: request a new number. Sampled at each edge.
- `rnd` output, WIDTH: last delivered number. Held between deliveries.
- `rnd_valid` output, 1: one-cycle pulse marking a new `rnd`.
- `busy` output, 1: request pending; waiting for an acceptable core value.

## Operation
- The core free-runs every cycle, whether or not a request is pending. Request timing therefore supplies the entropy.
- Additive core (`MODE`=0), registers A and B:
  - sum = A+B, computed at WIDTH+1 bits;
  - n = (sum > RANGE) ? sum−RANGE : sum;
  - if n = 0 then n = 1;
  - A ← n, B ← A.
  - Core value = A.
- LFSR core (`MODE`=1):
  - Galois right shift: next = (S>>1) ^ (S[0] ? TAPS[WIDTH] : 0).
  - A zero state is forced to 1.
  - Core value = S.
- Acceptable value: 1 ≤ core ≤ RANGE, and (with `MOLE_RNG_NO_REPEAT_EN`) core ≠ `rnd`.
- Seeding, when `seed_load`=1:
  - additive: A ← sanitised seed, B ← 1;
  - LFSR: S ← sanitised seed;
  - sanitised seed = 1 if `seed_in` = 0 or `seed_in` > RANGE (additive) / `seed_in` = 0 (LFSR), otherwise `seed_in`.
  - `seed_load` has priority over normal advance.
- FSM has two states:
  - IDLE, with `req`=1: if the core value is acceptable, capture it (`rnd` ← core, `rnd_valid`=1 next cycle) and stay in IDLE. Otherwise go to PEND.
  - PEND: on every edge, test the core value. On the first acceptable value, capture it, pulse `rnd_valid`, and return to IDLE.
  - `req` during PEND is ignored and not queued.
- Simultaneous events:
  - `req` with `seed_load`: the request tests the pre-load core value.
  - `seed_load` during PEND: the core reloads and the FSM stays in PEND.
  - `req` held high: one capture per cycle while values are acceptable.
- In additive mode the core is always in range. PEND is therefore reachable only through the no-repeat rule.

## Timing
- Reset values:
  - `rnd`=0, `rnd_valid`=0, `busy`=0, state IDLE;
  - A=`SEED_A`, B=`SEED_B`, S=`SEED_A`.
- Latency: `req` high at edge n with an acceptable core gives `rnd`/`rnd_valid` visible after edge n (1 cycle).
- Pending latency: in LFSR mode the worst case is 2^WIDTH−1 cycles. The bench asserts `busy` never lasts longer than this.
- `busy` is high from the edge that enters PEND until the capturing edge.
- Reset mid-PEND aborts the request. No `rnd_valid` is produced for it.

## Configuration
- `MOLE_RNG_NO_REPEAT_EN` defined: a value equal to the current `rnd` is rejected, so two consecutive deliveries always differ. With RANGE=1 this would deadlock, so RANGE must be ≥ 2.
- Not defined: any in-range value is accepted, and consecutive deliveries may be equal.

## Structure
- Package `mole_pkg` holds:
  - the LFSR tap table `MOLE_LFSR_TAPS[4..16]`, with WIDTH 4 = 4'hC and WIDTH 10 = 10'h240;
  - the FSM state enum (IDLE, PEND);
  - mode constants `MOLE_MODE_ADD` and `MOLE_MODE_LFSR`.
- Sub-module `mole_rng_core` holds the A/B/S registers, advance logic and seed sanitising. Its output is the core value. The top level holds the FSM and the output registers.

## Test plan
- Additive, defaults, `req` held from reset release → `rnd` = 1,2,3,5,8,13,21,34,55,89,144,233,377,110,487,97, one per cycle.
- Additive seeding: `seed_load` with `seed_in`=0, then `req` held → `rnd` = 1,2,3,5…; `seed_in`=600 behaves the same (sanitised to 1).
- LFSR, WIDTH=4, RANGE=5, SEED_A=1, `req` held:
  - core 1,12,6,3,13,…;
  - `rnd` = 1 after the first edge, then `busy`=1 for two cycles, then `rnd`=3;
  - all deliveries lie in 1..5.
- `MOLE_RNG_NO_REPEAT_EN`, LFSR WIDTH=4, RANGE=2, 200 random `req` pulses → no two consecutive `rnd` values equal; `busy` ≤ 15 cycles each time.
- `rst_n` low while `busy`=1 → `busy`, `rnd`, `rnd_valid` are 0 immediately. After release, `req` reproduces the reset sequence.
- `req` pulse during PEND plus `seed_load` → single `rnd_valid`, taken from the reloaded core sequence; the extra `req` is dropped.
